// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU (alu_seq) and its
// sequential multiplier (alu_mul_seq).
//   - OP_* : 3-bit operation encodings driven on alu_seq.op
//   - state_t : handshake state (ST_IDLE accepts, ST_BUSY multiplying)
//   - FLG_* : bit positions of Z/C/V/N inside the packed flag register
//   - pack_flags() : builds a packed flag vector from individual flags
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ADC = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;
  localparam int FLG_W = 4;

  function automatic logic [FLG_W-1:0] pack_flags(input logic z, input logic c,
                                                  input logic v, input logic n);
    logic [FLG_W-1:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : load a/b and begin; iterations run on the following WIDTH edges
//   a, b       : multiplicand / multiplier
//   done       : high during the cycle whose closing edge performs the last
//                iteration; product is valid in that same cycle
//   product    : full 2*WIDTH-bit product (combinational next accumulator)
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic               run_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] acc_next_s;

  // Partial product for the current multiplier bit and the next accumulator value.
  always_comb begin
    addend_s   = '0;
    acc_next_s = '0;
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = '0;
    end
    acc_next_s = acc_r + addend_s;
  end

  // Exposing the next accumulator lets the parent register the final product on
  // the same edge that performs the last iteration.
  assign done    = run_r && (cnt_r == LAST_CNT);
  assign product = acc_next_s;

  // Iteration state: load on start, then shift multiplicand left / multiplier right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r    <= 1'b0;
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (start) begin
      run_r    <= 1'b1;
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
    end else if (run_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (done) begin
        run_r <= 1'b0;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input handshake and persistent flags.
// Build option: define MUL_EN to make op 110 a WIDTH-cycle sequential multiply;
// without it op 110 is single-cycle and returns 0 (Z=1, other flags 0).
// Ports:
//   clk, rst_n         : clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready : input handshake; transfer when both high at an edge
//   op, a, b           : operation and operands
//   out_valid          : one-cycle pulse when result/flags were just updated
//   result             : registered result, held between pulses
//   flag_z/c/v/n       : registered zero / carry-borrow / overflow / negative
//   busy               : multiply in progress
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_r;
  logic [FLG_W-1:0] flags_r;
  logic             out_valid_r;

  logic [WIDTH:0]   ext_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [FLG_W-1:0] alu_flags_s;

  // Single-cycle datapath; arithmetic runs one bit wider to capture carry/borrow.
  always_comb begin
    ext_s       = '0;
    alu_res_s   = '0;
    alu_c_s     = 1'b0;
    alu_v_s     = 1'b0;
    case (op)
      OP_ADD: begin
        ext_s     = {1'b0, a} + {1'b0, b};
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
        alu_v_s   = (a[MSB] == b[MSB]) && (ext_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        ext_s     = {1'b0, a} - {1'b0, b};
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
        alu_v_s   = (a[MSB] != b[MSB]) && (ext_s[MSB] != a[MSB]);
      end
      OP_ADC: begin
        ext_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flags_r[FLG_C]};
        alu_res_s = ext_s[WIDTH-1:0];
        alu_c_s   = ext_s[WIDTH];
        alu_v_s   = (a[MSB] == b[MSB]) && (ext_s[MSB] != a[MSB]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_MOV:  alu_res_s = b;
      // Only registered when the multiplier is not built.
      OP_MUL:  alu_res_s = '0;
      default: alu_res_s = '0;
    endcase
    alu_flags_s = pack_flags(alu_res_s == '0, alu_c_s, alu_v_s, alu_res_s[MSB]);
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flag_z    = flags_r[FLG_Z];
  assign flag_c    = flags_r[FLG_C];
  assign flag_v    = flags_r[FLG_V];
  assign flag_n    = flags_r[FLG_N];

`ifdef MUL_EN
  state_t             state_r;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic               mul_hi_s;

  assign in_ready    = (state_r == ST_IDLE);
  assign busy        = (state_r == ST_BUSY);
  assign mul_start_s = in_valid && in_ready && (op == OP_MUL);
  // Any bit above the result width means the product was truncated.
  assign mul_hi_s    = |mul_prod_s[2*WIDTH-1:WIDTH];

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Handshake FSM plus result/flag registers; reset discards a multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_r <= ST_BUSY;
            end else begin
              result_r    <= alu_res_s;
              flags_r     <= alu_flags_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mul_done_s) begin
            state_r     <= ST_IDLE;
            result_r    <= mul_prod_s[WIDTH-1:0];
            flags_r     <= pack_flags(mul_prod_s[WIDTH-1:0] == '0, mul_hi_s,
                                      mul_hi_s, mul_prod_s[MSB]);
            out_valid_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  // Every accepted op completes in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= '0;
      flags_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (in_valid) begin
        result_r    <= alu_res_s;
        flags_r     <= alu_flags_s;
        out_valid_r <= 1'b1;
      end
    end
  end
`endif

endmodule
